// File: rtl/pipeline_ctrl_unit_if.sv
// Controller <-> fetch/decode/datapath signal bundle.
// master = pipeline_ctrl_unit, slave = decoder/datapath/BRAM side.
interface pipeline_ctrl_unit_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic [XLEN-1:0] inst_addra;
  logic [XLEN-1:0] PCout;
  logic [XLEN-1:0] dec_pc;
  logic            dec_valid;
  logic [RA_W-1:0] dec_rs1;
  logic [RA_W-1:0] dec_rs2;
  logic            dec_use_rs1;
  logic            dec_use_rs2;
  logic [RA_W-1:0] dec_rd;
  logic            dec_regwrite;
  logic            dec_is_load;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic [1:0]      fwd_sel_a;
  logic [1:0]      fwd_sel_b;
  logic            stall;
  logic            x_valid;
  logic            m_valid;
  logic [RA_W-1:0] x_rd;
  logic [RA_W-1:0] m_rd;
  logic            m_regwrite;

  modport master (
    output inst_addra, PCout,
    output dec_pc, dec_valid,
    input  dec_rs1, dec_rs2,
    input  dec_use_rs1, dec_use_rs2,
    input  dec_rd, dec_regwrite,
    input  dec_is_load,
    input  redirect_valid,
    input  redirect_target,
    output fwd_sel_a, fwd_sel_b,
    output stall,
    output x_valid, m_valid,
    output x_rd, m_rd,
    output m_regwrite
  );

  modport slave (
    input  inst_addra, PCout,
    input  dec_pc, dec_valid,
    output dec_rs1, dec_rs2,
    output dec_use_rs1, dec_use_rs2,
    output dec_rd, dec_regwrite,
    output dec_is_load,
    output redirect_valid,
    output redirect_target,
    input  fwd_sel_a, fwd_sel_b,
    input  stall,
    input  x_valid, m_valid,
    input  x_rd, m_rd,
    input  m_regwrite
  );
endinterface

// File: rtl/pipeline_ctrl_unit.sv
// Fetch/pipeline controller for the 3-stage F/D -> X -> M/WB core.
// Ports: Clock, Reset (sync, active-high), bus (pipeline_ctrl_unit_if.master).
module pipeline_ctrl_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              RA_W      = 5,
  parameter int              INST_STEP = 4
) (
  input  logic                Clock,
  input  logic                Reset,
  pipeline_ctrl_unit_if.master bus
);

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_X  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] dec_pc_q, dec_pc_d;
  logic            dec_valid_q, dec_valid_d;

  logic            x_valid_q, x_valid_d;
  logic [RA_W-1:0] x_rd_q, x_rd_d;
  logic            x_rw_q, x_rw_d;
  logic            x_ld_q, x_ld_d;
  logic [1:0]      fwd_a_q, fwd_a_d;
  logic [1:0]      fwd_b_q, fwd_b_d;

  logic            m_valid_q;
  logic [RA_W-1:0] m_rd_q;
  logic            m_rw_q;

  logic x_hit_a, x_hit_b;
  logic m_hit_a, m_hit_b;
  logic stall_c;
  logic do_redir, do_stall, do_seq;

  function automatic logic hit(
    input logic            v,
    input logic            rw,
    input logic [RA_W-1:0] srd,
    input logic [RA_W-1:0] src,
    input logic            use_s
  );
    return v & rw & (srd != '0) &
           (srd == src) & use_s;
  endfunction

  function automatic logic [1:0] sel(
    input logic xh,
    input logic mh
  );
    logic [1:0] s;
    s = FWD_RF;
    if (xh)
      s = FWD_X;
    else if (mh)
      s = FWD_M;
    return s;
  endfunction

  always_comb begin
    x_hit_a = hit(x_valid_q, x_rw_q, x_rd_q,
                  bus.dec_rs1, bus.dec_use_rs1);
    x_hit_b = hit(x_valid_q, x_rw_q, x_rd_q,
                  bus.dec_rs2, bus.dec_use_rs2);
    m_hit_a = hit(m_valid_q, m_rw_q, m_rd_q,
                  bus.dec_rs1, bus.dec_use_rs1);
    m_hit_b = hit(m_valid_q, m_rw_q, m_rd_q,
                  bus.dec_rs2, bus.dec_use_rs2);
  end

  // A redirect squashes the consumer anyway, so it
  // never waits on a load.
  assign stall_c = dec_valid_q & x_valid_q & x_ld_q &
                   (x_hit_a | x_hit_b) &
                   ~bus.redirect_valid;

  assign do_redir = bus.redirect_valid;
  assign do_stall = stall_c;
  assign do_seq   = ~bus.redirect_valid & ~stall_c;

  always_comb begin
    pc_d        = pc_q;
    dec_pc_d    = dec_pc_q;
    dec_valid_d = dec_valid_q;
    x_valid_d   = 1'b0;
    x_rd_d      = bus.dec_rd;
    x_rw_d      = bus.dec_regwrite;
    x_ld_d      = bus.dec_is_load;
    fwd_a_d     = FWD_RF;
    fwd_b_d     = FWD_RF;
    unique case (1'b1)
      do_redir: begin
        pc_d        = {bus.redirect_target[XLEN-1:1],
                       1'b0};
        dec_pc_d    = pc_q;
        dec_valid_d = 1'b0;
      end
      do_stall: begin
        // PC/decode hold; X takes a bubble.
      end
      do_seq: begin
        pc_d        = pc_q + XLEN'(INST_STEP);
        dec_pc_d    = pc_q;
        dec_valid_d = 1'b1;
        x_valid_d   = dec_valid_q;
        fwd_a_d     = sel(x_hit_a, m_hit_a);
        fwd_b_d     = sel(x_hit_b, m_hit_b);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q        <= RESET_PC;
      dec_pc_q    <= RESET_PC;
      dec_valid_q <= 1'b0;
      x_valid_q   <= 1'b0;
      x_rd_q      <= '0;
      x_rw_q      <= 1'b0;
      x_ld_q      <= 1'b0;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      m_valid_q   <= 1'b0;
      m_rd_q      <= '0;
      m_rw_q      <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      dec_pc_q    <= dec_pc_d;
      dec_valid_q <= dec_valid_d;
      x_valid_q   <= x_valid_d;
      x_rd_q      <= x_rd_d;
      x_rw_q      <= x_rw_d;
      x_ld_q      <= x_ld_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      m_valid_q   <= x_valid_q;
      m_rd_q      <= x_rd_q;
      m_rw_q      <= x_rw_q;
    end
  end

  // While stalled the BRAM re-reads the held
  // decode instruction.
  assign bus.inst_addra = stall_c ? dec_pc_q : pc_q;
  assign bus.PCout      = pc_q;
  assign bus.dec_pc     = dec_pc_q;
  assign bus.dec_valid  = dec_valid_q;
  assign bus.fwd_sel_a  = fwd_a_q;
  assign bus.fwd_sel_b  = fwd_b_q;
  assign bus.stall      = stall_c;
  assign bus.x_valid    = x_valid_q;
  assign bus.m_valid    = m_valid_q;
  assign bus.x_rd       = x_rd_q;
  assign bus.m_rd       = m_rd_q;
  assign bus.m_regwrite = m_valid_q & m_rw_q &
                          (m_rd_q != '0);

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Directed bench for pipeline_ctrl_unit.
// Drives decode/redirect, checks fetch, hazards, flush.
module tb_pipeline_ctrl_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  pipeline_ctrl_unit_if #(.XLEN(32), .RA_W(5)) bus();

  pipeline_ctrl_unit #(
    .XLEN(32),
    .RESET_PC(32'h0),
    .RA_W(5),
    .INST_STEP(4)
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic [4:0] rs1,
                     input logic u1,
                     input logic [4:0] rs2,
                     input logic u2,
                     input logic [4:0] rd,
                     input logic rw,
                     input logic ld);
    bus.dec_rs1      = rs1;
    bus.dec_use_rs1  = u1;
    bus.dec_rs2      = rs2;
    bus.dec_use_rs2  = u2;
    bus.dec_rd       = rd;
    bus.dec_regwrite = rw;
    bus.dec_is_load  = ld;
  endtask

  task automatic redir(input logic v,
                       input logic [31:0] t);
    bus.redirect_valid  = v;
    bus.redirect_target = t;
  endtask

  initial begin
    dec(0, 0, 0, 0, 0, 0, 0);
    redir(1'b0, 32'h0);
    rst = 1'b1;
    repeat (3) tick;
    chk("rst_pc", bus.PCout, 32'h0);
    chk("rst_addra", bus.inst_addra, 32'h0);
    chk("rst_dvalid", 32'(bus.dec_valid), 0);
    chk("rst_xvalid", 32'(bus.x_valid), 0);
    chk("rst_mvalid", 32'(bus.m_valid), 0);
    chk("rst_xrd", 32'(bus.x_rd), 0);
    chk("rst_mrd", 32'(bus.m_rd), 0);
    chk("rst_fwda", 32'(bus.fwd_sel_a), 0);
    chk("rst_fwdb", 32'(bus.fwd_sel_b), 0);
    chk("rst_mrw", 32'(bus.m_regwrite), 0);
    chk("rst_stall", 32'(bus.stall), 0);

    rst = 1'b0;
    tick;
    chk("f1_addra", bus.inst_addra, 32'h4);
    chk("f1_decpc", bus.dec_pc, 32'h0);
    chk("f1_dvalid", 32'(bus.dec_valid), 1);
    tick;
    chk("f2_addra", bus.inst_addra, 32'h8);
    chk("f2_decpc", bus.dec_pc, 32'h4);

    // add x5,x1,x2 ; add x6,x5,x5
    dec(1, 1, 2, 1, 5, 1, 0);
    tick;
    dec(5, 1, 5, 1, 6, 1, 0);
    tick;
    chk("fx_a", 32'(bus.fwd_sel_a), 1);
    chk("fx_b", 32'(bus.fwd_sel_b), 1);
    chk("fx_xrd", 32'(bus.x_rd), 6);
    chk("fx_mrd", 32'(bus.m_rd), 5);
    chk("fx_mrw", 32'(bus.m_regwrite), 1);

    // add x9 (independent) ; add x10,x6,x6
    dec(1, 1, 2, 1, 9, 1, 0);
    tick;
    dec(6, 1, 6, 1, 10, 1, 0);
    tick;
    chk("fm_a", 32'(bus.fwd_sel_a), 2);
    chk("fm_b", 32'(bus.fwd_sel_b), 2);
    chk("fm_decpc", bus.dec_pc, 32'd20);

    // lw x7 ; add x8,x7,x1
    dec(1, 1, 0, 0, 7, 1, 1);
    tick;
    dec(7, 1, 1, 1, 8, 1, 0);
    #1;
    chk("lu_stall", 32'(bus.stall), 1);
    chk("lu_addra", bus.inst_addra, 32'd24);
    chk("lu_pc", bus.PCout, 32'd28);
    tick;
    chk("lu_stall2", 32'(bus.stall), 0);
    chk("lu_pchold", bus.PCout, 32'd28);
    chk("lu_dechold", bus.dec_pc, 32'd24);
    chk("lu_dvalid", 32'(bus.dec_valid), 1);
    chk("lu_bubble", 32'(bus.x_valid), 0);
    chk("lu_addra2", bus.inst_addra, 32'd28);
    chk("lu_mrd", 32'(bus.m_rd), 7);
    tick;
    chk("lu_xvalid", 32'(bus.x_valid), 1);
    chk("lu_xrd", 32'(bus.x_rd), 8);
    chk("lu_fwda", 32'(bus.fwd_sel_a), 2);
    chk("lu_fwdb", 32'(bus.fwd_sel_b), 0);
    chk("lu_pc2", bus.PCout, 32'h20);

    // redirect to 0x101 at PC=0x20
    dec(0, 0, 0, 0, 0, 0, 0);
    redir(1'b1, 32'h101);
    #1;
    chk("rd_addra", bus.inst_addra, 32'h20);
    tick;
    redir(1'b0, 32'h0);
    chk("rd_pc", bus.PCout, 32'h100);
    chk("rd_dvalid", 32'(bus.dec_valid), 0);
    chk("rd_xvalid", 32'(bus.x_valid), 0);
    chk("rd_addra2", bus.inst_addra, 32'h100);
    tick;
    chk("rd_pc2", bus.PCout, 32'h104);
    chk("rd_decpc", bus.dec_pc, 32'h100);
    chk("rd_dvalid2", 32'(bus.dec_valid), 1);
    chk("rd_xvalid2", 32'(bus.x_valid), 0);

    // redirect and load-use together
    dec(1, 1, 0, 0, 7, 1, 1);
    tick;
    dec(7, 1, 0, 0, 8, 1, 0);
    redir(1'b1, 32'h200);
    #1;
    chk("rl_stall", 32'(bus.stall), 0);
    chk("rl_addra", bus.inst_addra, 32'h108);
    tick;
    redir(1'b0, 32'h0);
    dec(0, 0, 0, 0, 0, 0, 0);
    chk("rl_pc", bus.PCout, 32'h200);
    chk("rl_dvalid", 32'(bus.dec_valid), 0);
    chk("rl_xvalid", 32'(bus.x_valid), 0);
    chk("rl_mrd", 32'(bus.m_rd), 7);
    chk("rl_mrw", 32'(bus.m_regwrite), 1);
    tick;
    chk("rl_decpc", bus.dec_pc, 32'h200);
    chk("rl_dvalid2", 32'(bus.dec_valid), 1);

    // lw x0 ; add x11,x0,x0
    dec(1, 1, 0, 0, 0, 1, 1);
    tick;
    chk("z_xrd", 32'(bus.x_rd), 0);
    chk("z_xvalid", 32'(bus.x_valid), 1);
    dec(0, 1, 0, 1, 11, 1, 0);
    #1;
    chk("z_stall", 32'(bus.stall), 0);
    tick;
    chk("z_fwda", 32'(bus.fwd_sel_a), 0);
    chk("z_fwdb", 32'(bus.fwd_sel_b), 0);
    chk("z_mvalid", 32'(bus.m_valid), 1);
    chk("z_mrd", 32'(bus.m_rd), 0);
    chk("z_mrw", 32'(bus.m_regwrite), 0);

    // reset mid-stream with redirect
    dec(0, 0, 0, 0, 0, 0, 0);
    redir(1'b1, 32'h300);
    rst = 1'b1;
    tick;
    chk("mr_pc", bus.PCout, 32'h0);
    chk("mr_dvalid", 32'(bus.dec_valid), 0);
    chk("mr_xvalid", 32'(bus.x_valid), 0);
    chk("mr_mvalid", 32'(bus.m_valid), 0);
    chk("mr_mrw", 32'(bus.m_regwrite), 0);
    chk("mr_addra", bus.inst_addra, 32'h0);

    // PC wrap
    rst = 1'b0;
    redir(1'b1, 32'hFFFF_FFFC);
    tick;
    redir(1'b0, 32'h0);
    chk("w_pc", bus.PCout, 32'hFFFF_FFFC);
    tick;
    chk("w_pc2", bus.PCout, 32'h0);
    chk("w_decpc", bus.dec_pc, 32'hFFFF_FFFC);
    chk("w_dvalid", 32'(bus.dec_valid), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
